// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch stage (read-only) and the
//   memory stage (loads/stores). One transaction is outstanding at a time:
//   IDLE accepts a request, REQ presents it to memory until m_ack, RESP waits
//   for m_rvalid. The winning requester gets a one-cycle rvalid pulse.
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
//   requesters are pending; otherwise the data side always wins.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   i_req/i_addr          fetch read request (level, held until i_ready)
//   i_ready               fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata      fetch read return (pulse / held data)
//   d_req/d_we/d_addr/d_wdata  data load/store request
//   d_ready               data accepted this cycle (combinational)
//   d_rvalid/d_rdata      load data or store completion (rdata 0 on store)
//   m_req/m_we/m_addr/m_wdata  registered memory command
//   m_ack                 memory accepted the command
//   m_rvalid/m_rdata      memory read return
//   busy                  a transaction is in flight
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              r_state;
  logic                r_owner_d;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_idle;
  logic                w_grant_d;
  logic                w_grant_i;

  assign w_idle = (r_state == S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On contention the side that was not granted last wins.
  assign w_grant_d = d_req && (!i_req || !r_last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_idle && (d_req || i_req)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: the older (data-stage) instruction always goes first.
  assign w_grant_d = d_req;
`endif

  assign w_grant_i = i_req && !w_grant_d;

  assign i_ready  = w_idle && w_grant_i;
  assign d_ready  = w_idle && w_grant_d;
  assign busy     = !w_idle;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b1;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_i || w_grant_d) begin
            r_owner_d <= w_grant_d;
            r_m_req   <= 1'b1;
            r_m_we    <= w_grant_d && d_we;
            r_m_addr  <= w_grant_d ? d_addr : i_addr;
            r_m_wdata <= w_grant_d ? d_wdata : '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_ack) begin
            r_m_req <= 1'b0;
            if (r_m_we) begin
              // Only the data side can store, so completion always goes to D.
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (m_rvalid) begin
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= m_rdata;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= m_rdata;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, with a memory responder, a reference memory and a response queue.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference memory (bench model) and the responder's backing store.
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] mem     [0:255];

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- memory responder ----------------
  bit       rand_mode = 0;
  int       ack_dly   = 0;
  int       rv_dly    = 0;
  bit       spur_rv   = 0;
  int       rs        = 0;
  int       cnt       = 0;
  logic [7:0] p_idx;

  task automatic mem_ack();
    m_ack = 1'b1;
    p_idx = m_addr[9:2];
    if (m_we) begin
      mem[p_idx] = m_wdata;
      rs = 0;
    end else begin
      rs  = 2;
      cnt = rand_mode ? int'($urandom_range(0, 3)) : rv_dly;
    end
  endtask

  initial begin
    m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #2;
      m_ack = 1'b0;
      m_rvalid = 1'b0;
      case (rs)
        0: begin
          if (m_req) begin
            cnt = rand_mode ? int'($urandom_range(0, 3)) : ack_dly;
            if (cnt == 0) mem_ack();
            else rs = 1;
          end else if (rand_mode && $urandom_range(0, 5) == 0) begin
            m_ack = 1'b1;                                   // stray ack while idle
            if ($urandom_range(0, 1) == 0) begin m_rvalid = 1'b1; m_rdata = $urandom; end
          end
        end
        1: begin
          cnt--;
          if (cnt == 0) mem_ack();
          else if (rand_mode && $urandom_range(0, 2) == 0) begin
            m_rvalid = 1'b1; m_rdata = $urandom;            // stray rvalid during REQ
          end
        end
        default: begin
          if (cnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = mem[p_idx];
            rs = 0;
          end else begin
            cnt--;
            if (rand_mode && $urandom_range(0, 2) == 0) m_ack = 1'b1;  // stray ack during RESP
          end
        end
      endcase
      if (spur_rv) begin m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t          e;
  exp_t          n;
  bit            tb_last_d;
  bit            mreq_d;
  bit            hold_d;
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [DW-1:0] exp_i_last;
  logic [DW-1:0] exp_d_last;
  bit            exp_d;
  bit            model_idle;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      tb_last_d  = 1'b0;
      mreq_d     = 1'b0;
      hold_d     = 1'b0;
      exp_i_last = '0;
      exp_d_last = '0;
    end else begin
      if (i_rvalid || d_rvalid) begin
        chk("dual_rvalid", 32'(i_rvalid & d_rvalid), 32'd0);
        chk("rvalid_has_txn", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_owner_d", 32'(d_rvalid), 32'(e.is_d));
          if (e.is_d) exp_d_last = e.rdata;
          else        exp_i_last = e.rdata;
        end
      end
      chk("i_rdata", i_rdata, exp_i_last);
      chk("d_rdata", d_rdata, exp_d_last);
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));

      if (hold_d) begin
        chk("cmd_hold_req", 32'(m_req), 32'd1);
        chk("cmd_hold_addr", m_addr, hold_addr);
        chk("cmd_hold_we", 32'(m_we), 32'(hold_we));
        chk("cmd_hold_wdata", m_wdata, hold_wdata);
      end
      if (m_req && !mreq_d) begin
        chk("cmd_has_txn", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("cmd_addr", m_addr, exp_q[0].addr);
          chk("cmd_we", 32'(m_we), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("cmd_wdata", m_wdata, exp_q[0].wdata);
        end
      end
      hold_d     = m_req && !m_ack;
      hold_addr  = m_addr;
      hold_we    = m_we;
      hold_wdata = m_wdata;
      mreq_d     = m_req;

      model_idle = (exp_q.size() == 0);
      chk("accept", 32'(i_ready || d_ready), 32'(model_idle && (i_req || d_req)));
      if (model_idle && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = d_req && (!i_req || !tb_last_d);
`else
        exp_d = d_req;
`endif
        chk("grant_d", 32'(d_ready), 32'(exp_d));
        chk("grant_i", 32'(i_ready), 32'(!exp_d));
        tb_last_d = exp_d;
        if (exp_d) begin
          n.is_d = 1'b1; n.we = d_we; n.addr = d_addr; n.wdata = d_wdata;
          if (d_we) begin
            ref_mem[d_addr[9:2]] = d_wdata;
            n.rdata = '0;
          end else begin
            n.rdata = ref_mem[d_addr[9:2]];
          end
        end else begin
          n.is_d = 1'b0; n.we = 1'b0; n.addr = i_addr; n.wdata = '0;
          n.rdata = ref_mem[i_addr[9:2]];
        end
        exp_q.push_back(n);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      @(posedge clk); #3;
      k++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit exp_w [4];
  bit i_acc, d_acc, got;
  int nacc;
  logic [DW-1:0] v;

  initial begin
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 256; k++) begin
      v = $urandom;
      mem[k] = v; ref_mem[k] = v;
    end
    mem[4]  = 32'h00500093; ref_mem[4]  = 32'h00500093;
    mem[64] = 32'h11112222; ref_mem[64] = 32'h11112222;
    mem[65] = 32'h33334444; ref_mem[65] = 32'h33334444;

    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Contention: both requesters held for four transactions.
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h30;
    nacc = 0;
    for (int c = 0; c < 100 && nacc < 4; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        chk($sformatf("t3_win_d%0d", nacc), 32'(d_ready), 32'(exp_w[nacc]));
        chk($sformatf("t3_win_i%0d", nacc), 32'(i_ready), 32'(!exp_w[nacc]));
        nacc++;
      end
    end
    chk("t3_count", nacc, 32'd4);
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    drain();

    // Lone fetch, immediate ack, data one cycle later.
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    @(negedge clk); chk("t1_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1; i_req = 0;
    @(negedge clk);
    chk("t1_m_req", 32'(m_req), 32'd1);
    chk("t1_m_addr", m_addr, 32'h10);
    @(negedge clk); chk("t1_early_rvalid", 32'(i_rvalid), 32'd0);
    @(negedge clk);
    chk("t1_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h00500093);
    chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);
    drain();

    // Store with ack delayed three cycles.
    ack_dly = 3;
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("t2_d_ready", 32'(d_ready), 32'd1);
    @(posedge clk); #1; d_req = 0; d_we = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_m_req", 32'(m_req), 32'd1);
      chk("t2_m_we", 32'(m_we), 32'd1);
      chk("t2_m_addr", m_addr, 32'h40);
      chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    end
    @(negedge clk);
    chk("t2_ack_cycle_req", 32'(m_req), 32'd1);
    chk("t2_no_early_done", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t2_d_rdata", d_rdata, 32'd0);
    chk("t2_m_req_low", 32'(m_req), 32'd0);
    ack_dly = 0;
    drain();

    // Back-to-back loads.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk); chk("t4_ready1", 32'(d_ready), 32'd1);
    @(posedge clk); #1; d_addr = 32'h104;
    @(negedge clk); chk("t4_busy_no_ready", 32'(d_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_rvalid1", 32'(d_rvalid), 32'd1);
    chk("t4_ready2", 32'(d_ready), 32'd1);
    chk("t4_rdata1", d_rdata, 32'h11112222);
    @(posedge clk); #1; d_req = 0;
    repeat (3) @(negedge clk);
    chk("t4_rvalid2", 32'(d_rvalid), 32'd1);
    chk("t4_rdata2", d_rdata, 32'h33334444);
    drain();

    // Stray m_rvalid while idle.
    @(posedge clk); #1; spur_rv = 1;
    @(posedge clk); #1; spur_rv = 0;
    @(negedge clk);
    chk("t6_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    // Reset while waiting for read data; data arrives after release.
    rv_dly = 5;
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    @(negedge clk); chk("t5_d_ready", 32'(d_ready), 32'd1);
    @(posedge clk); #1; d_req = 0;
    repeat (3) @(negedge clk);
    chk("t5_busy_resp", 32'(busy), 32'd1);
    chk("t5_m_req_resp", 32'(m_req), 32'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cmd", 32'({m_req, m_we}), 32'd0);
    chk("t5_rst_m_addr", m_addr, 32'd0);
    chk("t5_rst_m_wdata", m_wdata, 32'd0);
    chk("t5_rst_i_rdata", i_rdata, 32'd0);
    chk("t5_rst_d_rdata", d_rdata, 32'd0);
    chk("t5_rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    @(posedge clk);
    @(posedge clk); #1; rst = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      chk("t5_idle", 32'(busy), 32'd0);
    end
    rv_dly = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    @(negedge clk); chk("t5_next_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1; i_req = 0;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (i_rvalid) got = 1;
    end
    chk("t5_next_rvalid", 32'(got), 32'd1);
    chk("t5_next_rdata", i_rdata, 32'h00500093);
    drain();

    // Randomized traffic with random memory latencies and stray handshakes.
    rand_mode = 1;
    i_acc = 0; d_acc = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (i_acc) i_req = 0;
      if (d_acc) d_req = 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = {22'd0, 8'($urandom), 2'b00};
        d_wdata = $urandom;
      end
      @(negedge clk);
      i_acc = i_ready;
      d_acc = d_ready;
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    drain();
    rand_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Accepts one request per transaction from either requester, drives the backing-memory request/ack/response interface, and returns read data or write completion to the winning requester. While a requester's `*_ready` is low, the pipeline stalls that stage. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch read request, level, held until accepted
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  instruction word
- d_req  in  1  data request, level, held until accepted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data; 0 on store completion
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  ADDR_W  memory address, registered
- m_wdata  out  DATA_W  memory write data, registered
- m_ack  in  1  memory accepted the request (same cycle as m_req)
- m_rvalid  in  1  memory read data valid
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if i_req or d_req, select a winner, assert that requester's ready (the other stays low), latch addr/we/wdata (we=0 for fetch) and owner, then go to REQ. Ready is only ever high in IDLE.
- REQ: hold m_req=1 with latched command until m_ack. On m_ack with a write: go to IDLE, and d_rvalid=1 with d_rdata=0 in the next cycle. On m_ack with a read: go to RESP.
- RESP: wait for m_rvalid. On m_rvalid: register m_rdata into the owner's rdata, pulse the owner's rvalid the next cycle, and go to IDLE.
- The non-owner's rvalid never asserts. The rdata outputs hold their last value between pulses.
- m_rvalid seen in IDLE or REQ is ignored. m_ack seen outside REQ is ignored.
- Arbitration: d_req beats i_req when both are high (oldest instruction first). A lone requester always wins.
- Both i_ready and d_ready low while busy=1.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, owner=D, last-grant=I.
  - All outputs 0: m_req, m_we, m_addr, m_wdata, i_rvalid, d_rvalid, i_rdata, d_rdata, busy.
- Reset mid-transaction abandons the transaction. No rvalid is issued, and late m_rvalid/m_ack are ignored.
- Accept at cycle T:
  - m_req high at T+1.
  - With m_ack at T+1: a write completes (d_rvalid) at T+2; a read enters RESP at T+2.
  - With m_rvalid at T+2: rvalid is at T+3.
- Minimum latency: read 3 cycles accept-to-rvalid; write 2 cycles.
- Back-to-back: the cycle in which rvalid pulses is IDLE, so a new request can be accepted in that same cycle.
- m_ack and m_rvalid may each be delayed indefinitely; m_req and command stay stable until m_ack.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requesters are high in IDLE, grant goes to the one not granted last.
  - The last-grant register updates on every accept; its reset value is I, so the first contended grant goes to D.
- Not defined: fixed priority, D always beats I. The last-grant register is not implemented.

## Test plan
- Lone fetch read, i_addr=0x10, memory acks at once and returns 0x00500093 one cycle later:
  - i_ready at T.
  - m_req/m_addr=0x10 at T+1.
  - i_rvalid with i_rdata=0x00500093 at T+3; d_rvalid stays 0.
- Store, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, m_ack delayed 3 cycles:
  - m_req held 3 cycles with stable command.
  - d_rvalid with d_rdata=0 one cycle after m_ack.
- Contention, i_req and d_req both high for 4 transactions:
  - Without the macro: D, D, D, D, with i_ready never high.
  - With ARB_ROUND_ROBIN_EN: D, I, D, I.
- Back-to-back loads at 0x100 and 0x104:
  - The second d_ready coincides with the first d_rvalid.
  - Return order matches m_rdata order.
- rst pulled low while in RESP, then m_rvalid arrives after release:
  - All outputs 0 and busy=0.
  - No rvalid pulse.
  - The next request is accepted normally.
- m_rvalid=1 while IDLE with no transaction: ignored, no rvalid, state stays IDLE.
